dmem_arbiter: RTL
=================

# dmem_arbiter

Shares the single data-memory port (dmem) between the CPU data_path and a host loader/debug port. CPU accesses pass straight through when the host is idle. The host issues word bursts with an auto-incrementing address, and the CPU stalls while the host owns the port. A starvation counter gives the CPU a guaranteed slot during long host bursts.

## Interface
- AW, 32, address width (byte address, word-aligned).
- DW, 32, data width.
- STARVE_LIMIT, 8, maximum consecutive host-granted cycles while cpu_req is pending; range 1..255.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- cpu_req  in  1  CPU wants a memory access this cycle.
- cpu_we  in  1  CPU write enable.
- cpu_addr  in  AW  CPU byte address.
- cpu_wdata  in  DW  CPU write data.
- cpu_rdata  out  DW  CPU read data, equal to mem_rdata.
- cpu_stall  out  1  CPU access not granted this cycle; data_path must hold.
- host_start  in  1  one-cycle burst command.
- host_we  in  1  burst direction, sampled with host_start (1 = write).
- host_addr  in  AW  burst start address, sampled with host_start.
- host_len  in  8  beat count, sampled with host_start.
- host_beat_valid  in  1  host offers a beat (write data valid or read wanted).
- host_wdata  in  DW  write beat data.
- host_ack  out  1  beat granted and performed this cycle.
- host_rdata  out  DW  read beat data, valid when host_ack=1.
- host_busy  out  1  burst in progress.
- host_done  out  1  one-cycle pulse after the last beat.
- mem_we  out  1  to dmem.we.
- mem_addr  out  AW  to dmem.addr.
- mem_wdata  out  DW  to dmem.write_data.
- mem_rdata  in  DW  from dmem.read_data (combinational read).

## Operation
- States: IDLE, BURST, CPU_SLOT.
- IDLE:
  - Port owned by CPU: mem_* = cpu_*, mem_we = cpu_req & cpu_we, cpu_stall = 0.
  - host_start with host_len != 0: latch addr/len/we, beat_cnt = host_len, go to BURST.
  - host_start with host_len = 0: no burst; host_done pulses next cycle.
- BURST: port owned by host.
  - mem_addr = burst address; mem_we = host_beat_valid & latched we.
  - host_ack = host_beat_valid.
  - cpu_stall = cpu_req.
  - On each ack: address += 4 (mod 2^AW, wraps silently) and beat_cnt -= 1.
  - Last ack (beat_cnt = 1): host_done pulses next cycle, go to IDLE.
- Starvation:
  - starve_cnt increments on each BURST cycle where cpu_req = 1 and host_ack = 1.
  - It clears on any cycle with cpu_req = 0.
  - When starve_cnt reaches STARVE_LIMIT and the burst is not finishing, go to CPU_SLOT.
- CPU_SLOT (one cycle):
  - Port owned by CPU as in IDLE; host_ack = 0 even if host_beat_valid.
  - starve_cnt clears; return to BURST.
- host_start while host_busy = 1 is ignored; no effect on the active burst.
- host_busy = 1 in BURST and CPU_SLOT.
- host_rdata = mem_rdata; cpu_rdata = mem_rdata.

## Timing
- Reset (reset = 0, asynchronous) clears everything immediately:
  - state = IDLE; host_busy, host_done, host_ack = 0.
  - starve_cnt, beat_cnt and burst address = 0.
  - mem_we is forced 0 while reset is low.
- Reset mid-burst aborts the burst: no host_done pulse, remaining beats are discarded.
- Grant outputs (cpu_stall, host_ack, mem_*) are combinational from state and inputs.
- A granted write commits at the rising edge closing its cycle; a granted read returns data in the same cycle.
- Burst start latency: host_start in cycle N makes the first beat grantable in cycle N+1.
- host_done is registered: it pulses in the cycle after the last ack, when state is already IDLE. A CPU access in that cycle is unstalled.
- Concurrent host_start and cpu_req in IDLE: the CPU access completes in that cycle; the burst starts next cycle.
- Worst-case CPU wait during a burst with continuous beats: STARVE_LIMIT cycles.

## Test plan
- CPU only, no host activity:
  - Write 0x0000_0005 to 0x14, then read 0x14.
  - cpu_stall stays 0 and cpu_rdata = 0x0000_0005.
- Host write burst, addr 0x40, len 4, data 0xA0..0xA3, continuous beat_valid:
  - 4 acks and words 0x40..0x4C written.
  - host_done pulses one cycle after the 4th ack; host_busy = 0 after that.
- CPU reads 0x44 during the above burst:
  - cpu_stall = 1 until the burst ends, then the read returns 0xA1.
- Starvation, STARVE_LIMIT = 3, len 10, cpu_req held:
  - Pattern is 3 host acks, 1 CPU_SLOT with cpu_stall = 0, repeating.
  - All 10 beats acked; total 13 cycles.
- Address wrap: burst at 0xFFFF_FFFC, len 2 → second beat at 0x0000_0000.
- Edge cases:
  - Reset low after the 2nd beat of a len 8 burst: host_busy = 0 immediately and no host_done.
  - Second host_start while busy is ignored.
  - host_len = 0: host_done pulses with no acks.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter between the CPU data path and a host burst loader.
// CPU passes through when the host is idle; a starvation counter forces CPU slots in long bursts.
module dmem_arbiter #(
  parameter int unsigned AW           = 32,
  parameter int unsigned DW           = 32,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_stall,
  input  logic          host_start,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [7:0]    host_len,
  input  logic          host_beat_valid,
  input  logic [DW-1:0] host_wdata,
  output logic          host_ack,
  output logic [DW-1:0] host_rdata,
  output logic          host_busy,
  output logic          host_done,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StBurst   = 2'd1;
  localparam logic [1:0] StCpuSlot = 2'd2;

  localparam logic [7:0] StarveLimit = 8'(STARVE_LIMIT);

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [7:0]    beat_cnt_q, beat_cnt_d;
  logic          we_q, we_d;
  logic [7:0]    starve_q, starve_d;
  logic          done_q, done_d;
  logic [7:0]    starve_inc;

  assign cpu_rdata  = mem_rdata;
  assign host_rdata = mem_rdata;
  assign host_busy  = (state_q != StIdle);
  assign host_done  = done_q;
  assign starve_inc = starve_q + 8'd1;

  // Port mux: host owns the port only in StBurst; StCpuSlot looks like idle to the CPU.
  always_comb begin
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    mem_we    = cpu_req & cpu_we;
    cpu_stall = 1'b0;
    host_ack  = 1'b0;
    if (state_q == StBurst) begin
      mem_addr  = addr_q;
      mem_wdata = host_wdata;
      mem_we    = host_beat_valid & we_q;
      host_ack  = host_beat_valid;
      cpu_stall = cpu_req;
    end
    if (!reset) mem_we = 1'b0;
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    beat_cnt_d = beat_cnt_q;
    we_d       = we_q;
    starve_d   = starve_q;
    done_d     = 1'b0;
    case (state_q)
      StIdle: begin
        starve_d = 8'd0;
        if (host_start) begin
          if (host_len == 8'd0) begin
            done_d = 1'b1;
          end else begin
            state_d    = StBurst;
            addr_d     = host_addr;
            beat_cnt_d = host_len;
            we_d       = host_we;
          end
        end
      end
      StBurst: begin
        if (!cpu_req) starve_d = 8'd0;
        else if (host_ack) starve_d = starve_inc;
        if (host_ack) begin
          addr_d     = addr_q + AW'(4);
          beat_cnt_d = beat_cnt_q - 8'd1;
          if (beat_cnt_q == 8'd1) begin
            done_d   = 1'b1;
            state_d  = StIdle;
            starve_d = 8'd0;
          end else if (cpu_req && starve_inc == StarveLimit) begin
            state_d = StCpuSlot;
          end
        end
      end
      StCpuSlot: begin
        starve_d = 8'd0;
        state_d  = StBurst;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      beat_cnt_q <= 8'd0;
      we_q       <= 1'b0;
      starve_q   <= 8'd0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      beat_cnt_q <= beat_cnt_d;
      we_q       <= we_d;
      starve_q   <= starve_d;
      done_q     <= done_d;
    end
  end

endmodule
